// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns a debounced button level into one-clock
// single-press, double-press, long-press and auto-repeat pulses, plus a
// busy flag that is high while a gesture is being classified.
// LONG_PRESS_CLOCK_PERIODS must be >= 2, DOUBLE_PRESS_GAP_CLOCK_PERIODS >= 1;
// REPEAT_CLOCK_PERIODS of 0 disables auto-repeat.
module button_gesture_decoder #(
  parameter int unsigned LONG_PRESS_CLOCK_PERIODS       = 1000,
  parameter int unsigned DOUBLE_PRESS_GAP_CLOCK_PERIODS = 300,
  parameter int unsigned REPEAT_CLOCK_PERIODS           = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic button_state,
  output logic single_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  localparam logic [31:0] LONG_LAST   = 32'(LONG_PRESS_CLOCK_PERIODS - 1);
  localparam logic [31:0] GAP_LAST    = 32'(DOUBLE_PRESS_GAP_CLOCK_PERIODS - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CLOCK_PERIODS - 1);
  localparam logic        REPEAT_ON   = (REPEAT_CLOCK_PERIODS != 0);

  // DOUBLE_DONE holds for one cycle after the second release so that the
  // double_press pulse and the drop of busy land one edge after the fall.
  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT_GAP,
    PRESSED2,
    DOUBLE_DONE,
    LONG_HELD
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        previous;
  logic        rise;
  logic        fall;
  logic [31:0] count;
  logic        count_reload;
  logic        count_clear;
  logic        single_next;
  logic        double_next;
  logic        long_next;
  logic        repeat_next;

  assign rise        = button_state & ~previous;
  assign fall        = ~button_state & previous;
  assign count_clear = count_reload | (next_state != state);

  // Previous-level register; resets high so a button held through reset is not a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      previous <= 1'b1;
    end else begin
      previous <= button_state;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Shared timer: cleared on state entry or repeat reload, saturates at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count_clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 32'd1;
    end
  end

  // Next-state and pulse decode; button edges take priority over timeouts.
  always_comb begin
    next_state   = state;
    count_reload = 1'b0;
    single_next  = 1'b0;
    double_next  = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = PRESSED1;
        end
      end
      PRESSED1: begin
        if (fall) begin
          next_state = WAIT_GAP;
        end else if (count == LONG_LAST) begin
          long_next  = 1'b1;
          next_state = LONG_HELD;
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          next_state = PRESSED2;
        end else if (count == GAP_LAST) begin
          single_next = 1'b1;
          next_state  = IDLE;
        end
      end
      PRESSED2: begin
        if (fall) begin
          next_state = DOUBLE_DONE;
        end
      end
      DOUBLE_DONE: begin
        double_next = 1'b1;
        next_state  = IDLE;
      end
      LONG_HELD: begin
        if (fall) begin
          next_state = IDLE;
        end else if (REPEAT_ON && (count == REPEAT_LAST)) begin
          repeat_next  = 1'b1;
          count_reload = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_press <= single_next;
      double_press <= double_next;
      long_press   <= long_next;
      repeat_press <= repeat_next;
      busy         <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: two instances (repeat on / repeat off)
// driven by the same directed button waveform, checked every cycle against a
// timestamp-based gesture model, plus literal pulse-edge expectations.
module tb_button_gesture_decoder;

  localparam int L   = 10;
  localparam int G   = 5;
  localparam int REP = 4;

  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       button_state;
  logic [4:0] o0;
  logic [4:0] o1;

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = -1;

  // Recorders: 0 = repeat DUT, 1 = no-repeat DUT, 2 = model of repeat DUT.
  int   cnt   [3][4];
  int   first [3][4];
  int   last  [3][4];
  int   brise [3];
  int   bfall [3];
  logic pbusy [3];

  typedef struct {
    bit         active;
    bit         prev;
    int         p1;
    int         r1;
    int         p2;
    int         r2;
    bit         long_hit;
    logic [4:0] out;   // {single, double, long, repeat, busy}
  } model_t;

  model_t mdl [2];

  button_gesture_decoder #(
    .LONG_PRESS_CLOCK_PERIODS      (L),
    .DOUBLE_PRESS_GAP_CLOCK_PERIODS(G),
    .REPEAT_CLOCK_PERIODS          (REP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button_state(button_state),
    .single_press(o0[4]),
    .double_press(o0[3]),
    .long_press  (o0[2]),
    .repeat_press(o0[1]),
    .busy        (o0[0])
  );

  button_gesture_decoder #(
    .LONG_PRESS_CLOCK_PERIODS      (L),
    .DOUBLE_PRESS_GAP_CLOCK_PERIODS(G),
    .REPEAT_CLOCK_PERIODS          (0)
  ) dut_norep (
    .clock       (clock),
    .reset       (reset),
    .button_state(button_state),
    .single_press(o1[4]),
    .double_press(o1[3]),
    .long_press  (o1[2]),
    .repeat_press(o1[1]),
    .busy        (o1[0])
  );

  always #5 clock = ~clock;

  function automatic model_t model_reset();
    model_t m;
    m.active   = 1'b0;
    m.prev     = 1'b1;
    m.p1       = -1;
    m.r1       = -1;
    m.p2       = -1;
    m.r2       = -1;
    m.long_hit = 1'b0;
    m.out      = '0;
    return m;
  endfunction

  // Gesture model in terms of press/release timestamps; n is the edge number.
  function automatic model_t model_step(model_t mi, bit b, int n, int rep);
    model_t m;
    bit rise;
    bit fall;
    m = mi;
    rise = b & ~m.prev;
    fall = ~b & m.prev;
    m.out = '0;
    if (!m.active) begin
      if (rise) begin
        m.active = 1'b1; m.p1 = n; m.r1 = -1; m.p2 = -1; m.r2 = -1; m.long_hit = 1'b0;
      end
    end else if (m.r2 >= 0) begin
      m.out[3] = 1'b1; m.active = 1'b0;
    end else if (m.p2 >= 0) begin
      if (fall) m.r2 = n;
    end else if (m.r1 >= 0) begin
      if (rise) m.p2 = n;
      else if (n == m.r1 + G) begin m.out[4] = 1'b1; m.active = 1'b0; end
    end else if (m.long_hit) begin
      if (fall) m.active = 1'b0;
      else if (rep != 0 && ((n - m.p1 - L) % rep) == 0) m.out[1] = 1'b1;
    end else begin
      if (fall) m.r1 = n;
      else if (n == m.p1 + L) begin m.out[2] = 1'b1; m.long_hit = 1'b1; end
    end
    m.out[0] = m.active;
    m.prev = b;
    return m;
  endfunction

  task automatic check_val(input string name, input int s, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s src=%0d got %0d expected %0d", name, s, got, exp);
    end
  endtask

  task automatic compare_out(input string name, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d got %b expected %b (single,double,long,repeat,busy)",
               name, edge_no, got, exp);
    end
  endtask

  task automatic record(input int s, input logic [4:0] v);
    for (int j = 0; j < 4; j++) begin
      if (v[4-j]) begin
        if (cnt[s][j] == 0) first[s][j] = edge_no;
        last[s][j] = edge_no;
        cnt[s][j]++;
      end
    end
    if (v[0] && !pbusy[s]) brise[s] = edge_no;
    if (!v[0] && pbusy[s]) bfall[s] = edge_no;
    pbusy[s] = v[0];
  endtask

  // Per-edge model update and comparison, sampled 1 time unit after the edge.
  always @(posedge clock) begin
    edge_no = edge_no + 1;
    for (int k = 0; k < 2; k++) begin
      if (!reset) mdl[k] = model_reset();
      else        mdl[k] = model_step(mdl[k], button_state, edge_no, (k == 0) ? REP : 0);
    end
    #1;
    compare_out("out_rep", o0, mdl[0].out);
    compare_out("out_norep", o1, mdl[1].out);
    record(0, o0);
    record(1, o1);
    record(2, mdl[0].out);
  end

  task automatic clear_rec();
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        cnt[s][j] = 0; first[s][j] = -1; last[s][j] = -1;
      end
      brise[s] = -1;
      bfall[s] = -1;
    end
  endtask

  // Called at a negedge: drive b for n edges, return positioned at a negedge.
  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      button_state = b;
      @(negedge clock);
    end
  endtask

  task automatic check_pulse(input string name, input int s, input int kind, input int base,
                             input int exp_cnt, input int exp_first, input int exp_last);
    check_val({name, "_count"}, s, cnt[s][kind], exp_cnt);
    if (exp_cnt > 0) begin
      check_val({name, "_first"}, s, first[s][kind] - base, exp_first);
      check_val({name, "_last"}, s, last[s][kind] - base, exp_last);
    end
  endtask

  // Same literal expectation on the repeat DUT and on the model.
  task automatic pins(input string name, input int kind, input int base,
                      input int exp_cnt, input int exp_first, input int exp_last);
    check_pulse(name, 0, kind, base, exp_cnt, exp_first, exp_last);
    check_pulse(name, 2, kind, base, exp_cnt, exp_first, exp_last);
  endtask

  int base;

  initial begin
    reset = 1'b0;
    button_state = 1'b0;
    clear_rec();
    for (int s = 0; s < 3; s++) pbusy[s] = 1'b0;
    @(negedge clock);
    #1;
    check_val("reset_outputs_rep", 0, int'(o0), 0);
    check_val("reset_outputs_norep", 1, int'(o1), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    hold(1'b0, 3);

    // Single press: press at 0, release at 3.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 3); hold(1'b0, 12);
    pins("single", K_SINGLE, base, 1, 8, 8);
    pins("single_nodouble", K_DOUBLE, base, 0, 0, 0);
    pins("single_nolong", K_LONG, base, 0, 0, 0);
    check_val("single_busy_rise", 0, brise[0] - base, 0);
    check_val("single_busy_fall", 0, bfall[0] - base, 8);
    check_val("single_busy_fall", 2, bfall[2] - base, 8);

    // Double press: press 0, release 3, press 6, release 9.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 10);
    pins("double", K_DOUBLE, base, 1, 10, 10);
    pins("double_nosingle", K_SINGLE, base, 0, 0, 0);
    pins("double_nolong", K_LONG, base, 0, 0, 0);
    check_val("double_busy_fall", 0, bfall[0] - base, 10);

    // Long press with repeat: held 0..19, fall sampled at 20.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 20); hold(1'b0, 10);
    pins("long", K_LONG, base, 1, 10, 10);
    pins("long_repeat", K_REPEAT, base, 2, 14, 18);
    pins("long_nosingle", K_SINGLE, base, 0, 0, 0);
    check_pulse("long_norep", 1, K_LONG, base, 1, 10, 10);
    check_pulse("long_norep_repeat", 1, K_REPEAT, base, 0, 0, 0);
    check_val("long_busy_fall", 0, bfall[0] - base, 20);

    // Release exactly on the long threshold edge.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 10); hold(1'b0, 12);
    pins("edge_release_nolong", K_LONG, base, 0, 0, 0);
    pins("edge_release_single", K_SINGLE, base, 1, 15, 15);

    // Second press exactly on the gap-timeout edge.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 3); hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, 10);
    pins("edge_press_nosingle", K_SINGLE, base, 0, 0, 0);
    pins("edge_press_double", K_DOUBLE, base, 1, 12, 12);

    // Button held through reset: no gesture at all.
    reset = 1'b0;
    hold(1'b1, 4);
    reset = 1'b1;
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 15); hold(1'b0, 15);
    for (int k = 0; k < 4; k++) begin
      check_pulse("held_reset_pulse", 0, k, base, 0, 0, 0);
      check_pulse("held_reset_pulse", 1, k, base, 0, 0, 0);
    end
    check_val("held_reset_busy", 0, brise[0], -1);

    // Reset asserted in the release gap: outputs drop at once, no late single.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 3); hold(1'b0, 2);
    @(posedge clock);
    #3;
    check_val("gap_busy_before_reset", 0, int'(o0[0]), 1);
    reset = 1'b0;
    #1;
    check_val("async_reset_rep", 0, int'(o0), 0);
    check_val("async_reset_norep", 1, int'(o1), 0);
    @(negedge clock);
    hold(1'b0, 3);
    reset = 1'b1;
    hold(1'b0, 15);
    pins("after_reset_nosingle", K_SINGLE, base, 0, 0, 0);
    check_pulse("after_reset_nosingle", 1, K_SINGLE, base, 0, 0, 0);

    // Long hold of 40 cycles: repeat DUT repeats, no-repeat DUT gives only long.
    clear_rec(); base = edge_no + 1;
    hold(1'b1, 40); hold(1'b0, 10);
    check_pulse("hold40_norep_long", 1, K_LONG, base, 1, 10, 10);
    check_pulse("hold40_norep_repeat", 1, K_REPEAT, base, 0, 0, 0);
    check_pulse("hold40_norep_single", 1, K_SINGLE, base, 0, 0, 0);
    pins("hold40_repeat", K_REPEAT, base, 7, 14, 38);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
